main_memory_responder: RTL
==========================

Name: main_memory_responder

Overview:
- Memory-side responder for the cache controller's block-transfer interface: addr_mem, bidirectional data_mem, read_mem_enable, write_mem_enable and ready_memory.
- Serves block refills (reads) and dirty-block write-backs (writes) of 4 bytes per block.
- Applies a programmable access latency, signalled by dropping ready_memory, then performs the 4-beat burst.
- Serves as the main-memory model in cache benches and as the synthesizable backing store in the top-level.

Parameters:
ADDR_W, 16, address width on addr_mem
DATA_W, 8, width of data_mem and of each stored byte
MEM_AW, 16, implemented storage address bits; address bits above MEM_AW are ignored (aliasing)
LATENCY, 4, cycles ready_memory is held low before a burst; 0 allowed

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
addr_mem  input  ADDR_W  byte address from cache; bits [1:0] = byte within block
data_mem  inout  DATA_W  driven by memory only during a read burst, high-Z otherwise
read_mem_enable  input  1  block refill request, level
write_mem_enable  input  1  block write-back request, level
ready_memory  output  1  low = busy/latency phase, high = idle or burst beat

Behaviour:
- Reset (reset=0, asynchronous):
  - ready_memory=1, data_mem high-Z, FSM to IDLE, counters cleared.
  - Array contents are not reset.
  - Reset mid-transaction aborts it; bytes already written stay written.
- States: IDLE, WAIT, RD_BURST, WR_BURST, DONE.
- IDLE:
  - At a rising edge with either enable high: latch block address addr_mem[ADDR_W-1:2] and the operation.
  - write_mem_enable has priority when both enables are high.
  - LATENCY>0: go to WAIT with lat_cnt=LATENCY-1.
  - LATENCY=0: go directly to the burst state.
- WAIT:
  - ready_memory=0 for exactly LATENCY cycles; decrement lat_cnt each cycle.
  - At 0, go to RD_BURST or WR_BURST.
- Bursts: ready_memory=1 and beat counter beat 0..3 (2-bit, wraps).
- RD_BURST:
  - In burst cycle k, data_mem carries mem[{blk,beat_k}] from a registered output with registered output-enable.
  - Exactly 4 cycles, then DONE.
  - data_mem returns to high-Z in the cycle after beat 3.
- WR_BURST:
  - Memory never drives data_mem.
  - At the rising edge ending burst cycle k, data_mem is written to mem[{blk,k}] (k=0..3).
  - Exactly 4 cycles, then DONE.
- DONE:
  - ready_memory=1.
  - Stay until both enables are low, then IDLE.
  - A held enable therefore never restarts a second transaction.
- Enables dropping mid-transaction are ignored; the transaction completes. addr_mem changes after acceptance are ignored.
- Total read latency, accept edge to beat 0: LATENCY+1 cycles.
- Address math is unsigned; the byte index is {blk, beat}, truncated to MEM_AW.

Optional Feature:
MEM_CRITICAL_WORD_FIRST_EN:
- Defined: read burst beat k returns byte index (addr_mem[1:0]+k) mod 4 (latched start offset, wrapping).
- Write bursts are unaffected.
- Undefined: reads always start at byte 0; addr_mem[1:0] is ignored.

Decomposition:
- Shared package mem_if_pkg holds:
  - state enum (IDLE, WAIT, RD_BURST, WR_BURST, DONE)
  - BLOCK_BYTES=4, BEAT_W=2, default ADDR_W/DATA_W
  - op encoding (OP_RD, OP_WR)
- One sub-module, mem_byte_array: single-port, synchronous write, registered read, 2^MEM_AW x DATA_W.
  - Read address is supplied one cycle ahead so beat data aligns with the burst cycle.

Test Plan:
1. Hold reset=0 for 4 cycles with read_mem_enable=1 -> ready_memory=1, data_mem=Z throughout; no transaction after release until the enable toggles.
2. Write to addr 0xC08B with bytes 11,22,33,44 (LATENCY=4) -> ready_memory low exactly 4 cycles after the accept edge, then 4 sampled beats; a read of 0xC088 returns 11,22,33,44 on beats 0..3, with beat 0 at accept+5.
3. Both enables high at 0x011F (stored AA,BB,CC,DD) -> write served first; read_mem_enable held through DONE is ignored until both enables are low, then the read returns the newly written data.
4. Reset asserted in WAIT of a read -> ready_memory=1 and data_mem=Z asynchronously; memory unchanged; next read of the same block completes normally.
5. Macro defined, read 0xC08A of block 11,22,33,44 -> beats 33,44,11,22; macro undefined -> 11,22,33,44.
6. LATENCY=0 read -> ready_memory never low; beat 0 on the cycle after accept; data_mem=Z the cycle after beat 3.

Source files
------------

// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared types and constants for the main-memory block-transfer interface
package mem_if_pkg;

    localparam int BLOCK_BYTES = 4;
    localparam int BEAT_W      = 2;
    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DATA_W  = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT     = 3'd1,
        RD_BURST = 3'd2,
        WR_BURST = 3'd3,
        DONE     = 3'd4
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

endpackage

// File: rtl/mem_byte_array.sv
// rtl/mem_byte_array.sv - single-port byte store, synchronous write, registered read
module mem_byte_array #(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input  logic          clock_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clock_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/main_memory_responder.sv
// rtl/main_memory_responder.sv - latency + 4-beat burst responder for cache refills/write-backs
// Optional MEM_CRITICAL_WORD_FIRST_EN: read bursts start at the requested byte and wrap.
module main_memory_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MEM_AW  = 16,
    parameter int LATENCY = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr_mem,
    inout  wire  [DATA_W-1:0] data_mem,
    input  logic              read_mem_enable,
    input  logic              write_mem_enable,
    output logic              ready_memory
);

    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int BLK_W = ADDR_W - BEAT_W;

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [BLK_W-1:0]    blk_q, blk_d;
    logic [BEAT_W-1:0]   off_q, off_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic                oe_q, oe_d;
    logic                armed_q, armed_d;

    logic                any_en;
    logic [BEAT_W-1:0]   start_off;
    logic [BLK_W-1:0]    rd_blk;
    logic [BEAT_W-1:0]   rd_idx;
    logic [ADDR_W-1:0]   byte_idx;
    logic [MEM_AW-1:0]   arr_addr;
    logic [DATA_W-1:0]   arr_rdata;
    logic                arr_we;

    assign any_en = read_mem_enable | write_mem_enable;

`ifdef MEM_CRITICAL_WORD_FIRST_EN
    assign start_off = addr_mem[BEAT_W-1:0];
`else
    assign start_off = '0;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        blk_d   = blk_q;
        off_d   = off_q;
        beat_d  = beat_q;
        lat_d   = lat_q;
        // After reset an enable that was already high must drop before it can start a transfer.
        armed_d = armed_q | ~any_en;
        case (state_q)
            IDLE: begin
                if (armed_q && any_en) begin
                    blk_d  = addr_mem[ADDR_W-1:BEAT_W];
                    op_d   = write_mem_enable ? OP_WR : OP_RD;
                    off_d  = start_off;
                    beat_d = '0;
                    if (LATENCY == 0) begin
                        state_d = write_mem_enable ? WR_BURST : RD_BURST;
                    end else begin
                        state_d = WAIT;
                        lat_d   = LAT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (lat_q == '0) begin
                    state_d = (op_q == OP_WR) ? WR_BURST : RD_BURST;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            RD_BURST, WR_BURST: begin
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!any_en) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        oe_d = (state_d == RD_BURST);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= OP_RD;
            blk_q   <= '0;
            off_q   <= '0;
            beat_q  <= '0;
            lat_q   <= '0;
            oe_q    <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            blk_q   <= blk_d;
            off_q   <= off_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
            oe_q    <= oe_d;
            armed_q <= armed_d;
        end
    end

    // The array address selects the byte shown in the *next* cycle, so a read beat is ready on time.
    assign rd_blk   = (state_q == IDLE) ? addr_mem[ADDR_W-1:BEAT_W] : blk_q;
    assign rd_idx   = ((state_q == IDLE) ? start_off : off_q)
                    + ((state_q == RD_BURST) ? beat_q + 2'd1 : 2'd0);
    assign arr_we   = (state_q == WR_BURST);
    assign byte_idx = arr_we ? {blk_q, beat_q} : {rd_blk, rd_idx};
    assign arr_addr = MEM_AW'(byte_idx);

    mem_byte_array #(
        .AW (MEM_AW),
        .DW (DATA_W)
    ) u_array (
        .clock_i (clock),
        .we_i    (arr_we),
        .addr_i  (arr_addr),
        .wdata_i (data_mem),
        .rdata_o (arr_rdata)
    );

    assign data_mem     = oe_q ? arr_rdata : {DATA_W{1'bz}};
    assign ready_memory = (state_q != WAIT);

endmodule
